// File: rtl/cpu_clk_pkg.sv
// ----------------------------------------------------------------------------
// cpu_clk_pkg
// Shared definitions for the CPU clock controller:
//   - mode encodings for the run / step / pause selector
//   - default rate-select value (bus_clk period 2^25 clk cycles)
//   - rise_allowed(): decides whether a bus_clk low phase may end at a tick
// ----------------------------------------------------------------------------
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_STEP    = 2'b01,
        MODE_PAUSE   = 2'b10,
        MODE_PAUSE_X = 2'b11   // unused encoding, behaves exactly like pause
    } mode_e;

    localparam int unsigned DEFAULT_DIV_SEL = 32'd24;

    // A new high phase may start only without a halt request, and then
    // either freely (run) or once per accepted button press (step).
    function automatic logic rise_allowed(input logic [1:0] mode,
                                          input logic       hlt,
                                          input logic       step_pending);
        logic ok;
        case (mode)
            MODE_RUN:  ok = !hlt;
            MODE_STEP: ok = !hlt && step_pending;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
// Synchronises a raw asynchronous push-button and accepts a new level only
// after it has been seen unchanged for DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   btn_raw   raw button input, active-high, asynchronous to clk
//   btn_rise  one-clk registered strobe on an accepted 0->1 transition
// ----------------------------------------------------------------------------
module button_debounce
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_WIDTH        = 20
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_rise
);

    localparam logic [DB_WIDTH-1:0] CNT_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_WIDTH-1:0] CNT_ONE  = {{(DB_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DB_WIDTH-1:0] CNT_ZERO = {DB_WIDTH{1'b0}};

    logic                sync1_q;
    logic                sync2_q;
    logic                stable_q;
    logic                stable_d;
    logic                rise_q;
    logic                rise_d;
    logic [DB_WIDTH-1:0] cnt_q;
    logic [DB_WIDTH-1:0] cnt_d;

    // Debounce: count while the synchronised level disagrees with the
    // accepted level; any agreement restarts the count from zero.
    always_comb begin
        stable_d = stable_q;
        rise_d   = 1'b0;
        cnt_d    = CNT_ZERO;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                rise_d   = sync2_q;
                cnt_d    = CNT_ZERO;
            end else begin
                cnt_d    = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = CNT_ZERO;
        end
    end

    // Synchroniser, accepted level, debounce counter and edge strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= CNT_ZERO;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign btn_rise = rise_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_clock_ctrl
// Registered, glitch-free CPU bus clock generator driven by a free-running
// prescaler, with run / single-step / pause modes and a halt input.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   mode         00 run, 01 step, 10/11 pause
//   div_sel      rate select, bus_clk period = 2^(div_sel+1) clk (tap clamped)
//   step_btn     raw step push-button, active-high
//   hlt          halt request, level; honoured only while bus_clk is low
//   bus_clk      registered bus clock
//   control_clk  registered complement of bus_clk
//   bus_rise     strobe in the first cycle bus_clk reads 1
//   bus_fall     strobe in the first cycle bus_clk reads 0
//   halted       hlt && !bus_clk
//   cycle_count  count of bus_clk rising edges, wraps
// ----------------------------------------------------------------------------
module cpu_clock_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DIV_WIDTH       = 32,
    parameter int DIV_SEL_W       = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_WIDTH        = 20,
    parameter int CNT_WIDTH       = 16
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic [DIV_SEL_W-1:0] div_sel,
    input  logic                 step_btn,
    input  logic                 hlt,
    output logic                 bus_clk,
    output logic                 control_clk,
    output logic                 bus_rise,
    output logic                 bus_fall,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam logic [DIV_SEL_W-1:0] MAX_TAP = DIV_SEL_W'(DIV_WIDTH - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_WIDTH-1:0] prescaler_q;
    logic [DIV_WIDTH-1:0] prescaler_d;
    logic                 bus_clk_q;
    logic                 bus_clk_d;
    logic                 control_clk_q;
    logic                 control_clk_d;
    logic                 bus_rise_q;
    logic                 bus_rise_d;
    logic                 bus_fall_q;
    logic                 bus_fall_d;
    logic [CNT_WIDTH-1:0] cycle_count_q;
    logic [CNT_WIDTH-1:0] cycle_count_d;
    logic                 step_pending_q;
    logic                 step_pending_d;

    logic [DIV_SEL_W-1:0] tap_s;
    logic [DIV_WIDTH-1:0] tap_mask_s;
    logic                 tick_s;
    logic                 rise_ok_s;
    logic                 press_s;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_WIDTH        (DB_WIDTH)
    ) u_step_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (step_btn),
        .btn_rise (press_s)
    );

    // Tick selection: the low k prescaler bits all ones mark the end of a
    // phase. k=0 gives an all-zero mask, so every cycle is a tick. Because the
    // tap is re-evaluated each cycle, a div_sel change simply moves the next
    // phase boundary to the first tick of the new tap.
    always_comb begin
        if (div_sel > MAX_TAP) begin
            tap_s = MAX_TAP;
        end else begin
            tap_s = div_sel;
        end
        tap_mask_s = (DIV_ONE << tap_s) - DIV_ONE;
        tick_s     = ((prescaler_q & tap_mask_s) == tap_mask_s);
        rise_ok_s  = rise_allowed(mode, hlt, step_pending_q);
    end

    // Next-state for the bus clock, strobes and rise counter. A started high
    // phase always ends at its tick; only the start of a high phase is gated.
    always_comb begin
        prescaler_d   = prescaler_q + DIV_ONE;
        bus_clk_d     = bus_clk_q;
        bus_rise_d    = 1'b0;
        bus_fall_d    = 1'b0;
        cycle_count_d = cycle_count_q;
        if (tick_s) begin
            if (bus_clk_q) begin
                bus_clk_d  = 1'b0;
                bus_fall_d = 1'b1;
            end else if (rise_ok_s) begin
                bus_clk_d     = 1'b1;
                bus_rise_d    = 1'b1;
                cycle_count_d = cycle_count_q + CNT_ONE;
            end else begin
                bus_clk_d = 1'b0;
            end
        end else begin
            bus_clk_d = bus_clk_q;
        end
        control_clk_d = ~bus_clk_d;
    end

    // Step request: armed by one accepted press while low and idle, consumed
    // by the rise it enables, and dropped as soon as step mode is left. A
    // press and a rise cannot coincide since one needs pending clear and the
    // other pending set, so a press blocked by hlt stays pending.
    always_comb begin
        if (mode != MODE_STEP) begin
            step_pending_d = 1'b0;
        end else if (bus_rise_d) begin
            step_pending_d = 1'b0;
        end else if (press_s && !bus_clk_q && !step_pending_q) begin
            step_pending_d = 1'b1;
        end else begin
            step_pending_d = step_pending_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q    <= {DIV_WIDTH{1'b0}};
            bus_clk_q      <= 1'b0;
            control_clk_q  <= 1'b1;
            bus_rise_q     <= 1'b0;
            bus_fall_q     <= 1'b0;
            cycle_count_q  <= {CNT_WIDTH{1'b0}};
            step_pending_q <= 1'b0;
        end else begin
            prescaler_q    <= prescaler_d;
            bus_clk_q      <= bus_clk_d;
            control_clk_q  <= control_clk_d;
            bus_rise_q     <= bus_rise_d;
            bus_fall_q     <= bus_fall_d;
            cycle_count_q  <= cycle_count_d;
            step_pending_q <= step_pending_d;
        end
    end

    assign bus_clk     = bus_clk_q;
    assign control_clk = control_clk_q;
    assign bus_rise    = bus_rise_q;
    assign bus_fall    = bus_fall_q;
    assign cycle_count = cycle_count_q;
    assign halted      = hlt & ~bus_clk_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cpu_clock_ctrl
// Self-checking bench for cpu_clock_ctrl: table of run-mode rates from reset,
// hand sequences for step / halt / rate change / async reset / wrap / mode 11,
// and a randomized run compared cycle by cycle against a behavioural model.
// Small parameters keep the run short: 6-bit prescaler (div_sel 6,7 clamp to
// tap 5), 4-cycle debounce, 10-bit cycle counter.
// ----------------------------------------------------------------------------
module tb_cpu_clock_ctrl;

    localparam int DIV_WIDTH = 6;
    localparam int DIV_SEL_W = 3;
    localparam int DEB       = 4;
    localparam int DB_WIDTH  = 3;
    localparam int CNT_WIDTH = 10;
    localparam int CNT_MOD   = 1 << CNT_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           mode;
    logic [DIV_SEL_W-1:0] div_sel;
    logic                 step_btn;
    logic                 hlt;
    logic                 bus_clk;
    logic                 control_clk;
    logic                 bus_rise;
    logic                 bus_fall;
    logic                 halted;
    logic [CNT_WIDTH-1:0] cycle_count;

    always #5 clk = ~clk;

    cpu_clock_ctrl #(
        .DIV_WIDTH       (DIV_WIDTH),
        .DIV_SEL_W       (DIV_SEL_W),
        .DEBOUNCE_CYCLES (DEB),
        .DB_WIDTH        (DB_WIDTH),
        .CNT_WIDTH       (CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .div_sel     (div_sel),
        .step_btn    (step_btn),
        .hlt         (hlt),
        .bus_clk     (bus_clk),
        .control_clk (control_clk),
        .bus_rise    (bus_rise),
        .bus_fall    (bus_fall),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // cycles since reset release, plus tallies over the current window
    int cyc;
    int rises;
    int highs;
    int first_rise;

    // behavioural model state
    int m_t;
    int m_cnt;
    bit m_bus, m_rise, m_fall, m_pend;
    bit m_s1, m_s2, m_stable, m_press;
    int m_run;   // consecutive samples where the synced button disagrees

    typedef struct {
        int ds;
        int exp_rises;
        int exp_highs;
        int exp_first;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_cnt = 0; m_bus = 0; m_rise = 0; m_fall = 0; m_pend = 0;
        m_s1 = 0; m_s2 = 0; m_stable = 0; m_press = 0; m_run = 0;
        cyc = 0;
    endtask

    task automatic clear_tally();
        rises = 0; highs = 0; first_rise = 0;
    endtask

    // Advance the model across one rising clk edge using the current inputs.
    task automatic model_step();
        int  k, p;
        bit  tick, nb, nr, nf, np, npress;
        int  nc;
        k    = (int'(div_sel) > DIV_WIDTH - 1) ? DIV_WIDTH - 1 : int'(div_sel);
        p    = 1 << k;
        tick = ((m_t % p) == p - 1);
        nb = m_bus; nr = 0; nf = 0; nc = m_cnt;
        if (tick && m_bus) begin
            nb = 0; nf = 1;
        end else if (tick && !hlt && (mode == 2'b00 || (mode == 2'b01 && m_pend))) begin
            nb = 1; nr = 1; nc = (m_cnt + 1) % CNT_MOD;
        end
        if (mode != 2'b01)                        np = 0;
        else if (nr)                              np = 0;
        else if (m_press && !m_bus && !m_pend)    np = 1;
        else                                      np = m_pend;
        npress = 0;
        if (m_s2 != m_stable) begin
            if (m_run == DEB - 1) begin
                m_stable = m_s2; npress = m_s2; m_run = 0;
            end else begin
                m_run++;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1; m_s1 = step_btn; m_press = npress;
        m_bus = nb; m_rise = nr; m_fall = nf; m_cnt = nc; m_pend = np;
        m_t++;
    endtask

    task automatic compare_model(input string name);
        logic [14:0] a, e;
        logic [31:0] c;
        c = m_cnt;
        a = {bus_clk, control_clk, bus_rise, bus_fall, halted, cycle_count};
        e = {m_bus, !m_bus, m_rise, m_fall, hlt && !m_bus, c[CNT_WIDTH-1:0]};
        check(name, int'(a), int'(e));
    endtask

    // One clk cycle: model advance, clock edge, sample at the falling edge.
    task automatic clk_cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (bus_rise) begin
            rises++;
            if (first_rise == 0) first_rise = cyc;
        end
        if (bus_clk) highs++;
        compare_model("model");
    endtask

    // Synchronous-looking reset pulse, entered and left at a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_bus_clk", int'(bus_clk), 0);
        check("reset_ctrl_clk", int'(control_clk), 1);
        check("reset_strobes", int'({bus_rise, bus_fall}), 0);
        check("reset_count", int'(cycle_count), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_tally();
    endtask

    task automatic wait_rise(input string name, input int bound, output bit got);
        got = 0;
        for (int i = 0; i < bound; i++) begin
            clk_cycle();
            if (bus_rise) begin
                got = 1;
                break;
            end
        end
        check(name, int'(got), 1);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit got;
        int len;
        int q[$];
        int bad;
        int hold;

        // run mode for 32 clk after reset; rises at P,3P,..; highs 16 unless P=32
        tbl[0] = '{0, 16, 16, 1};
        tbl[1] = '{1,  8, 16, 2};
        tbl[2] = '{2,  4, 16, 4};
        tbl[3] = '{3,  2, 16, 8};
        tbl[4] = '{4,  1, 16, 16};
        tbl[5] = '{5,  1,  1, 32};
        tbl[6] = '{7,  1,  1, 32};   // clamped to tap 5

        rst_n = 1'b0; mode = 2'b00; div_sel = 3'd2; step_btn = 1'b0; hlt = 1'b0;
        model_reset();
        clear_tally();
        @(negedge clk);

        // ---- table: rate select from reset in run mode --------------------
        for (int i = 0; i < 7; i++) begin
            mode = 2'b00; hlt = 1'b0; step_btn = 1'b0;
            div_sel = DIV_SEL_W'(tbl[i].ds);
            do_reset();
            repeat (32) clk_cycle();
            check($sformatf("tbl%0d_rises", i), rises, tbl[i].exp_rises);
            check($sformatf("tbl%0d_highs", i), highs, tbl[i].exp_highs);
            check($sformatf("tbl%0d_first", i), first_rise, tbl[i].exp_first);
            check($sformatf("tbl%0d_count", i), int'(cycle_count), tbl[i].exp_rises);
        end

        // ---- step mode: clean press, glitch, press during high phase ------
        mode = 2'b01; div_sel = 3'd3;
        do_reset();
        step_btn = 1'b1;
        repeat (10) clk_cycle();
        step_btn = 1'b0;
        repeat (40) clk_cycle();
        check("step_rises", rises, 1);
        check("step_highs", highs, 8);
        check("step_count", int'(cycle_count), 1);
        check("step_align", first_rise % 8, 0);

        clear_tally();
        step_btn = 1'b1;
        repeat (3) clk_cycle();
        step_btn = 1'b0;
        repeat (40) clk_cycle();
        check("glitch_rises", rises, 0);
        check("glitch_count", int'(cycle_count), 1);

        div_sel = 3'd5;
        clear_tally();
        step_btn = 1'b1;
        got = 0;
        for (int i = 1; i <= 80; i++) begin
            clk_cycle();
            if (i == 8) step_btn = 1'b0;
            if (bus_rise) begin
                got = 1;
                break;
            end
        end
        check("step2_rise", int'(got), 1);
        step_btn = 1'b0;
        repeat (8) clk_cycle();
        step_btn = 1'b1;        // accepted while bus_clk is still high
        repeat (10) clk_cycle();
        step_btn = 1'b0;
        repeat (60) clk_cycle();
        check("step2_rises", rises, 1);
        check("step2_count", int'(cycle_count), 2);

        // ---- hlt asserted one clk into a high phase ------------------------
        mode = 2'b00; div_sel = 3'd2;
        do_reset();
        wait_rise("hlt_wait_rise", 20, got);
        len = 1;
        clk_cycle();
        if (bus_clk) len++;
        hlt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clk_cycle();
            if (bus_fall) break;
            if (bus_clk) len++;
        end
        check("hlt_high_len", len, 4);
        clear_tally();
        repeat (12) clk_cycle();
        check("hlt_no_rise", rises, 0);
        check("hlt_halted", int'(halted), 1);
        hlt = 1'b0;
        #1;
        check("hlt_released", int'(halted), 0);
        wait_rise("hlt_resume", 4, got);
        check("hlt_resume_align", cyc % 4, 0);

        // ---- div_sel 4 -> 1 during a high phase ----------------------------
        mode = 2'b00; div_sel = 3'd4;
        do_reset();
        wait_rise("div_wait_rise", 40, got);
        repeat (3) clk_cycle();
        div_sel = 3'd1;
        len = 4;
        q.delete();
        for (int i = 0; i < 24; i++) begin
            logic prev;
            prev = bus_clk;
            clk_cycle();
            if (bus_clk != prev) begin
                q.push_back(len);
                len = 1;
            end else begin
                len++;
            end
        end
        check("div_phase_cnt_ok", int'(q.size() >= 8), 1);
        if (q.size() > 0) check("div_first_phase", q[0], 4);
        bad = 0;
        for (int i = 1; i < q.size(); i++) if (q[i] != 2) bad++;
        check("div_later_phases", bad, 0);

        // ---- asynchronous reset in the middle of a high phase --------------
        mode = 2'b00; div_sel = 3'd2;
        do_reset();
        wait_rise("arst_wait_rise", 20, got);
        clk_cycle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_bus_clk", int'(bus_clk), 0);
        check("arst_ctrl_clk", int'(control_clk), 1);
        check("arst_count", int'(cycle_count), 0);
        #4 rst_n = 1'b1;
        @(negedge clk);
        model_reset();
        clear_tally();
        wait_rise("arst_first_rise", 10, got);
        check("arst_first_rise_at", cyc, 4);

        // ---- cycle_count wrap at all ones ----------------------------------
        mode = 2'b00; div_sel = 3'd0;
        do_reset();
        repeat (2 * CNT_MOD - 3) clk_cycle();
        check("wrap_max", int'(cycle_count), CNT_MOD - 1);
        repeat (2) clk_cycle();
        check("wrap_zero", int'(cycle_count), 0);

        // ---- mode 11 behaves as pause -------------------------------------
        div_sel = 3'd2;
        do_reset();
        wait_rise("m11_wait_rise", 20, got);
        len = 1;
        clk_cycle();
        if (bus_clk) len++;
        mode = 2'b11;
        for (int i = 0; i < 10; i++) begin
            clk_cycle();
            if (bus_fall) break;
            if (bus_clk) len++;
        end
        check("m11_high_len", len, 4);
        clear_tally();
        repeat (40) clk_cycle();
        check("m11_no_rise", rises, 0);
        check("m11_bus_low", int'(bus_clk), 0);

        // ---- randomized run against the model ------------------------------
        mode = 2'b01; div_sel = 3'd1; hlt = 1'b0; step_btn = 1'b0;
        do_reset();
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0)
                div_sel = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                      : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 39) == 0) hlt = ~hlt;
            if (hold == 0) begin
                step_btn = 1'($urandom_range(0, 1));
                hold     = $urandom_range(1, 12);
            end
            hold--;
            clk_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
